select_mode_fsm: RTL and testbench

Parametrised game-mode selector that supersedes the fixed two-mode screen selector. It decodes a one-hot switch request over `N_MODES` modes and filters it for stability over `STABLE_CYCLES`. A mode change passes through a blanking interval of `BLANK_CYCLES` with the screen forced idle, and the block honours a lock from the game core. It sits between the board switch inputs and the screen/game multiplexers in the 65 MHz domain.

---
 rtl/select_mode_fsm.sv | 152 +++++++++++++++
 tb/tb_select_mode_fsm.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/select_mode_fsm.sv
// Debounced one-hot game-mode selector with a blanking interval between modes and a game-core lock.
// Latency: STABLE_CYCLES to accept a request, plus BLANK_CYCLES before a mode goes active; no handshake, lock holds ACTIVE.
module select_mode_fsm #(
   parameter int N_MODES       = 2,
   parameter int STABLE_CYCLES = 4,
   parameter int BLANK_CYCLES  = 8
) (
   input  logic                       clk65MHz,
   input  logic                       rst,
   input  logic [15:0]                sw,
   input  logic                       lock,
   output logic                       screen_idle,
   output logic [N_MODES-1:0]         mode_onehot,
   output logic [$clog2(N_MODES)-1:0] mode_idx,
   output logic                       mode_change
);

   localparam int IW  = $clog2(N_MODES);
   localparam int MW  = $clog2(N_MODES + 1);
   localparam int CW  = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam int BCW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

   localparam logic [MW-1:0]  MODE_IDLE = MW'(N_MODES);
   localparam logic [CW-1:0]  CNT_MAX   = CW'(STABLE_CYCLES - 1);
   localparam logic [BCW-1:0] BCNT_MAX  = BCW'(BLANK_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BLANK  = 2'd1,
      ST_ACTIVE = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   target, target_nxt;
   logic [BCW-1:0]  bcnt, bcnt_nxt;
   logic [MW-1:0]   cand;
   logic [CW-1:0]   cnt;

   logic [MW-1:0]   req_ones;
   logic [IW-1:0]   req_mode;
   logic [MW-1:0]   decoded;
   logic            acc_vld, acc_idle, acc_mode;
   logic [IW-1:0]   acc_idx;

   logic               screen_idle_nxt;
   logic [N_MODES-1:0] mode_onehot_nxt;
   logic [IW-1:0]      mode_idx_nxt;
   logic               mode_change_nxt;

   // Anything other than exactly one set switch is treated as an idle request.
   always_comb begin
      req_ones = '0;
      req_mode = '0;
      for (int i = 0; i < N_MODES; i++) begin
         if (sw[i]) begin
            req_ones = req_ones + MW'(1);
            req_mode = IW'(i);
         end
      end
      decoded = (req_ones == MW'(1)) ? MW'(req_mode) : MODE_IDLE;
   end

   always_ff @(posedge clk65MHz) begin
      if (rst) begin
         cand <= MODE_IDLE;
         cnt  <= '0;
      end else if (decoded != cand) begin
         cand <= decoded;
         cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign acc_vld  = (cnt == CNT_MAX) && (decoded == cand);
   assign acc_idle = acc_vld && (cand == MODE_IDLE);
   assign acc_mode = acc_vld && (cand != MODE_IDLE);
   assign acc_idx  = cand[IW-1:0];

   always_ff @(posedge clk65MHz) begin
      if (rst) begin
         state       <= ST_IDLE;
         target      <= '0;
         bcnt        <= '0;
         screen_idle <= 1'b1;
         mode_onehot <= '0;
         mode_idx    <= '0;
         mode_change <= 1'b0;
      end else begin
         state       <= state_nxt;
         target      <= target_nxt;
         bcnt        <= bcnt_nxt;
         screen_idle <= screen_idle_nxt;
         mode_onehot <= mode_onehot_nxt;
         mode_idx    <= mode_idx_nxt;
         mode_change <= mode_change_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      target_nxt = target;
      bcnt_nxt   = bcnt;
      case (state)
         ST_IDLE: begin
            if (acc_mode) begin
               target_nxt = acc_idx;
               bcnt_nxt   = '0;
               state_nxt  = ST_BLANK;
            end
         end
         ST_BLANK: begin
            if (acc_idle) begin
               state_nxt = ST_IDLE;
            end else if (acc_mode && (acc_idx != target)) begin
               // A different accepted mode restarts the whole blank interval.
               target_nxt = acc_idx;
               bcnt_nxt   = '0;
            end else if (bcnt == BCNT_MAX) begin
               state_nxt = ST_ACTIVE;
            end else begin
               bcnt_nxt = bcnt + BCW'(1);
            end
         end
         ST_ACTIVE: begin
            if (!lock) begin
               if (acc_idle) begin
                  state_nxt = ST_IDLE;
               end else if (acc_mode && (acc_idx != target)) begin
                  target_nxt = acc_idx;
                  bcnt_nxt   = '0;
                  state_nxt  = ST_BLANK;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are computed from the next state so they line up with the state register.
   always_comb begin
      screen_idle_nxt = (state_nxt != ST_ACTIVE);
      mode_onehot_nxt = '0;
      mode_idx_nxt    = '0;
      if (state_nxt == ST_ACTIVE) begin
         mode_onehot_nxt[target_nxt] = 1'b1;
         mode_idx_nxt                = target_nxt;
      end
      mode_change_nxt = (state_nxt == ST_ACTIVE) != (state == ST_ACTIVE);
   end

endmodule

// File: tb/tb_select_mode_fsm.sv
// Directed bench for select_mode_fsm with N_MODES=4, STABLE_CYCLES=4, BLANK_CYCLES=8.
// Each vector holds inputs for ncyc edges, then checks outputs and the mode_change pulse count.
module tb_select_mode_fsm;

   logic        clk65MHz = 1'b0;
   logic        rst;
   logic [15:0] sw;
   logic        lock;
   logic        screen_idle;
   logic [3:0]  mode_onehot;
   logic [1:0]  mode_idx;
   logic        mode_change;

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   always #5 clk65MHz = ~clk65MHz;

   select_mode_fsm #(
      .N_MODES      (4),
      .STABLE_CYCLES(4),
      .BLANK_CYCLES (8)
   ) dut (
      .clk65MHz   (clk65MHz),
      .rst        (rst),
      .sw         (sw),
      .lock       (lock),
      .screen_idle(screen_idle),
      .mode_onehot(mode_onehot),
      .mode_idx   (mode_idx),
      .mode_change(mode_change)
   );

   typedef struct {
      logic       rst;
      logic [3:0] sw;
      logic       lock;
      int         ncyc;
      logic       exp_idle;
      logic [3:0] exp_oh;
      logic [1:0] exp_idx;
      logic       exp_chg;
      int         exp_pulses;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic [3:0] s, input logic l, input int n,
                               input logic ei, input logic [3:0] eo, input logic [1:0] ex,
                               input logic ec, input int ep);
      vec_t v;
      v.rst = r; v.sw = s; v.lock = l; v.ncyc = n;
      v.exp_idle = ei; v.exp_oh = eo; v.exp_idx = ex; v.exp_chg = ec; v.exp_pulses = ep;
      return v;
   endfunction

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   // One edge; outputs sampled 1 ns later, pulses counted, exclusivity checked.
   task automatic tick();
      @(posedge clk65MHz);
      #1;
      if (mode_change === 1'b1) pulses++;
      check("idle_xor_mode", -1, 32'(screen_idle), 32'(mode_onehot == 4'b0000));
   endtask

   initial begin
      rst  = 1'b1;
      sw   = 16'h0000;
      lock = 1'b0;

      //                rst   sw      lock n   idle  oh      idx  chg  pulses
      vecs.push_back(mk(1'b1, 4'b0000, 1'b0, 2, 1'b1, 4'b0000, 2'd0, 1'b0, 0)); // reset
      vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 6, 1'b1, 4'b0000, 2'd0, 1'b0, 0));
      vecs.push_back(mk(1'b0, 4'b0001, 1'b0, 4, 1'b1, 4'b0000, 2'd0, 1'b0, 0)); // select 0
      vecs.push_back(mk(1'b0, 4'b0001, 1'b0, 1, 1'b1, 4'b0000, 2'd0, 1'b0, 0)); // BLANK
      vecs.push_back(mk(1'b0, 4'b0001, 1'b0, 7, 1'b1, 4'b0000, 2'd0, 1'b0, 0));
      vecs.push_back(mk(1'b0, 4'b0001, 1'b0, 1, 1'b0, 4'b0001, 2'd0, 1'b1, 1)); // ACTIVE
      vecs.push_back(mk(1'b0, 4'b0001, 1'b0, 1, 1'b0, 4'b0001, 2'd0, 1'b0, 0));
      vecs.push_back(mk(1'b0, 4'b0011, 1'b0, 3, 1'b0, 4'b0001, 2'd0, 1'b0, 0)); // invalid combo
      vecs.push_back(mk(1'b0, 4'b0011, 1'b0, 1, 1'b0, 4'b0001, 2'd0, 1'b0, 0));
      vecs.push_back(mk(1'b0, 4'b0011, 1'b0, 1, 1'b1, 4'b0000, 2'd0, 1'b1, 1));
      vecs.push_back(mk(1'b0, 4'b0011, 1'b0, 1, 1'b1, 4'b0000, 2'd0, 1'b0, 0));
      vecs.push_back(mk(1'b0, 4'b0010, 1'b0, 3, 1'b1, 4'b0000, 2'd0, 1'b0, 0)); // glitch
      vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 10, 1'b1, 4'b0000, 2'd0, 1'b0, 0));
      vecs.push_back(mk(1'b0, 4'b0001, 1'b0, 13, 1'b0, 4'b0001, 2'd0, 1'b1, 1)); // back to 0
      vecs.push_back(mk(1'b0, 4'b0100, 1'b1, 20, 1'b0, 4'b0001, 2'd0, 1'b0, 0)); // locked
      vecs.push_back(mk(1'b0, 4'b0100, 1'b0, 1, 1'b1, 4'b0000, 2'd0, 1'b1, 1)); // unlock
      vecs.push_back(mk(1'b0, 4'b0100, 1'b0, 7, 1'b1, 4'b0000, 2'd0, 1'b0, 0));
      vecs.push_back(mk(1'b0, 4'b0100, 1'b0, 1, 1'b0, 4'b0100, 2'd2, 1'b1, 1)); // mode 2
      vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 6, 1'b1, 4'b0000, 2'd0, 1'b0, 1)); // to IDLE
      vecs.push_back(mk(1'b0, 4'b0001, 1'b0, 4, 1'b1, 4'b0000, 2'd0, 1'b0, 0)); // retarget
      vecs.push_back(mk(1'b0, 4'b0001, 1'b0, 2, 1'b1, 4'b0000, 2'd0, 1'b0, 0));
      vecs.push_back(mk(1'b0, 4'b1000, 1'b0, 5, 1'b1, 4'b0000, 2'd0, 1'b0, 0));
      vecs.push_back(mk(1'b0, 4'b1000, 1'b0, 3, 1'b1, 4'b0000, 2'd0, 1'b0, 0));
      vecs.push_back(mk(1'b0, 4'b1000, 1'b0, 4, 1'b1, 4'b0000, 2'd0, 1'b0, 0));
      vecs.push_back(mk(1'b0, 4'b1000, 1'b0, 1, 1'b0, 4'b1000, 2'd3, 1'b1, 1)); // mode 3
      vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 6, 1'b1, 4'b0000, 2'd0, 1'b0, 1));
      vecs.push_back(mk(1'b0, 4'b0001, 1'b0, 6, 1'b1, 4'b0000, 2'd0, 1'b0, 0)); // mid-BLANK
      vecs.push_back(mk(1'b1, 4'b0001, 1'b0, 1, 1'b1, 4'b0000, 2'd0, 1'b0, 0)); // reset
      vecs.push_back(mk(1'b0, 4'b0001, 1'b0, 12, 1'b1, 4'b0000, 2'd0, 1'b0, 0));
      vecs.push_back(mk(1'b0, 4'b0001, 1'b0, 1, 1'b0, 4'b0001, 2'd0, 1'b1, 1));
      vecs.push_back(mk(1'b1, 4'b0001, 1'b0, 1, 1'b1, 4'b0000, 2'd0, 1'b0, 0)); // reset in ACTIVE
      vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 5, 1'b1, 4'b0000, 2'd0, 1'b0, 0));

      foreach (vecs[i]) begin
         rst    = vecs[i].rst;
         sw     = {12'hF0F, vecs[i].sw};
         lock   = vecs[i].lock;
         pulses = 0;
         repeat (vecs[i].ncyc) tick();
         check("screen_idle", i, 32'(screen_idle), 32'(vecs[i].exp_idle));
         check("mode_onehot", i, 32'(mode_onehot), 32'(vecs[i].exp_oh));
         check("mode_idx",    i, 32'(mode_idx),    32'(vecs[i].exp_idx));
         check("mode_change", i, 32'(mode_change), 32'(vecs[i].exp_chg));
         check("pulse_count", i, 32'(pulses),      32'(vecs[i].exp_pulses));
      end

      // Lock held from IDLE through BLANK must not delay entry: ACTIVE exactly 12 edges after the first sample.
      sw   = 16'h0002;
      lock = 1'b1;
      for (int c = 1; c <= 13; c++) begin
         tick();
         check("lockblank_idle", 100 + c, 32'(screen_idle), 32'(c < 13));
         check("lockblank_chg",  100 + c, 32'(mode_change), 32'(c == 13));
      end
      check("lockblank_idx", 114, 32'(mode_idx), 32'd1);

      // Idle request while locked is held off until lock drops.
      sw = 16'h0000;
      for (int c = 1; c <= 6; c++) begin
         tick();
         check("locked_hold", 120 + c, 32'(mode_onehot), 32'h2);
      end
      lock = 1'b0;
      tick();
      check("unlock_idle", 127, 32'(screen_idle), 32'd1);
      check("unlock_chg",  127, 32'(mode_change), 32'd1);
      tick();
      check("unlock_chg_end", 128, 32'(mode_change), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
